// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use a radix-2 shift-add and DIV/DIVU a restoring shift-subtract,
// both on operand magnitudes, followed by a one-cycle sign-fix step.
// MTHI/MTLO writes go straight into hi/lo while the unit is idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated (dividend < 0)
    logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;       // {upper, lower}: product or {remainder, quotient}

    // Absolute value for signed ops; unsigned ops pass the operand through.
    // The most negative value maps to itself, which read unsigned is 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic sgn);
        if (sgn && (v < 0))
            return -v;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                     input logic en);
        return en ? -v : v;
    endfunction

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // One radix-2 iteration for each operation, plus the sign-fixed result.
    always_comb begin
        a_mag = magnitude(a, op[0]);
        b_mag = magnitude(b, op[0]);

        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift right keeping the carry.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder and
        // keep the difference only if it did not borrow.
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        if (div_trial[WIDTH])
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        else
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        // Divide by zero and MIN_NEG / -1 fall out of the magnitude datapath
        // with the required results, so no special cases are needed here.
        prod_fix = cond_neg2(acc, neg_res);
        if (is_div) begin
            res_hi = cond_neg(acc[2*WIDTH-1:WIDTH], neg_rem);
            res_lo = cond_neg(acc[WIDTH-1:0], neg_res);
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opb     <= '0;
            acc     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_hi)
                        hi <= wdata;
                    if (wr_lo)
                        lo <= wdata;
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= op[0] & a[WIDTH-1];
                        if (op[1]) begin
                            opb <= b_mag;
                            acc <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opb <= a_mag;
                            acc <= {{WIDTH{1'b0}}, b_mag};
                        end
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance, table vectors,
// handshake/reset corner sequences and randomized ops against a reference
// model built from plain integer arithmetic.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, wr_hi32, wr_lo32, busy32, done32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wdata32, hi32, lo32;
    logic        start8, wr_hi8, wr_lo8, busy8, done8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8, hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .wr_hi(wr_hi32), .wr_lo(wr_lo32), .wdata(wdata32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wdata(wdata8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference results {hi, lo} from integer arithmetic.
    function automatic logic [63:0] ref32(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint px, py;
        int sx, sy, q, m;
        logic [63:0] r;
        sx = x;
        sy = y;
        case (o)
            2'd0: r = {32'b0, x} * {32'b0, y};
            2'd1: begin
                px = longint'(sx);
                py = longint'(sy);
                r = px * py;
            end
            2'd2: begin
                if (y == 0) r = {x, 32'hFFFFFFFF};
                else        r = {x % y, x / y};
            end
            default: begin
                if (y == 0)
                    r = {x, (sx < 0) ? 32'd1 : 32'hFFFFFFFF};
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    r = {32'd0, 32'h80000000};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m, q};
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [15:0] ref8(input logic [1:0] o, input logic [7:0] x,
                                         input logic [7:0] y);
        int ux, uy, sx, sy, p, q, m;
        byte bx, by;
        logic [15:0] r;
        ux = {24'b0, x};
        uy = {24'b0, y};
        bx = x;
        by = y;
        sx = int'(bx);
        sy = int'(by);
        case (o)
            2'd0: begin p = ux * uy; r = p[15:0]; end
            2'd1: begin p = sx * sy; r = p[15:0]; end
            2'd2: begin
                if (uy == 0) r = {x, 8'hFF};
                else begin
                    q = ux / uy;
                    m = ux % uy;
                    r = {m[7:0], q[7:0]};
                end
            end
            default: begin
                if (sy == 0)
                    r = {x, (sx < 0) ? 8'd1 : 8'hFF};
                else if (sx == -128 && sy == -1)
                    r = {8'd0, 8'h80};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[7:0], q[7:0]};
                end
            end
        endcase
        return r;
    endfunction

    task automatic issue(input bit w8, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        if (w8) begin
            start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        end
    endtask

    // Steps negedges from count n0+1 until done; n counts edges with the
    // start edge as 1. Drops start after the first edge.
    task automatic wait_done(input bit w8, input int n0, output int lat, output int bc,
                             output logic [31:0] h, output logic [31:0] l);
        bit to;
        lat = 0; bc = 0; h = '0; l = '0; to = 1'b1;
        for (int n = n0 + 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (w8) start8 = 1'b0;
                else    start32 = 1'b0;
            end
            if (w8 ? busy8 : busy32) bc++;
            if (w8 ? done8 : done32) begin
                lat = n;
                h = w8 ? {24'b0, hi8} : hi32;
                l = w8 ? {24'b0, lo8} : lo32;
                to = 1'b0;
                break;
            end
        end
        if (to) begin
            total++;
            bad++;
            $display("FAIL timeout: no done within 200 cycles (w8=%0d)", w8);
        end
    endtask

    function automatic logic [31:0] pick(input bit w8);
        logic [31:0] v;
        int k;
        k = int'($urandom_range(0, 7));
        case (k)
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFFFFFF;
            3: v = w8 ? 32'h80 : 32'h80000000;
            default: v = $urandom;
        endcase
        if (w8) v = v & 32'hFF;
        return v;
    endfunction

    initial begin
        int lat, bc, ndone;
        logic [31:0] h, l, x, y;
        logic [1:0] o;
        logic [63:0] e32;
        logic [15:0] e8;

        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[4]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[5]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{2'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'd1};
        vecs[8]  = '{2'd0, 32'd6,        32'd7,        32'd0,        32'd42};
        vecs[9]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
        vecs[10] = '{2'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[11] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};

        reset = 1'b1;
        start32 = 0; op32 = 0; a32 = 0; b32 = 0; wr_hi32 = 0; wr_lo32 = 0; wdata32 = 0;
        start8 = 0;  op8 = 0;  a8 = 0;  b8 = 0;  wr_hi8 = 0;  wr_lo8 = 0;  wdata8 = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy32), 64'd0);
        chk("reset_done", 64'(done32), 64'd0);
        chk("reset_hilo", {hi32, lo32}, 64'd0);
        chk("reset_hilo8", 64'({hi8, lo8, busy8, done8}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, each started on the done cycle of the previous one.
        for (int i = 0; i < 12; i++) begin
            issue(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1'b0, 0, lat, bc, h, l);
            chk($sformatf("vec%0d_hi", i), 64'(h), 64'(vecs[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(l), 64'(vecs[i].lo));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done32), 64'd0);

        // MTHI / MTLO while idle.
        wr_hi32 = 1'b1; wdata32 = 32'h5A5A;
        @(negedge clk);
        wr_hi32 = 1'b0;
        chk("mthi_hi", 64'(hi32), 64'h5A5A);
        chk("mthi_no_done", 64'(done32), 64'd0);
        wr_lo32 = 1'b1; wdata32 = 32'hA5A5;
        @(negedge clk);
        wr_lo32 = 1'b0;
        chk("mtlo_hilo", {hi32, lo32}, {32'h5A5A, 32'hA5A5});
        wr_hi32 = 1'b1; wr_lo32 = 1'b1; wdata32 = 32'h77;
        @(negedge clk);
        wr_hi32 = 1'b0; wr_lo32 = 1'b0;
        chk("mt_both", {hi32, lo32}, {32'h77, 32'h77});
        chk("mt_both_no_done", 64'(done32 | busy32), 64'd0);
        wr_lo32 = 1'b1; wdata32 = 32'hA5A5;
        @(negedge clk);
        wr_lo32 = 1'b0;

        // DIVU 100/7 with a start and an MTLO attempted mid-run.
        issue(1'b0, 2'd2, 32'd100, 32'd7);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start32 = 1'b0;
            wr_lo32 = 1'b0;
            if (n == 5) begin issue(1'b0, 2'd0, 32'd1, 32'd1); end
            if (n == 6) begin wr_lo32 = 1'b1; wdata32 = 32'h55; end
        end
        chk("run_hilo_stable", {hi32, lo32}, {32'h77, 32'hA5A5});
        wait_done(1'b0, 7, lat, bc, h, l);
        chk("ignored_start_result", {h, l}, {32'd2, 32'd14});
        chk("ignored_start_latency", 64'(lat), 64'd34);

        // MTHI in the same cycle as an accepted start.
        @(negedge clk);
        issue(1'b0, 2'd1, 32'hFFFFFFFE, 32'd3);
        wr_hi32 = 1'b1; wdata32 = 32'h1234;
        @(negedge clk);
        start32 = 1'b0; wr_hi32 = 1'b0;
        chk("start_write_hi", 64'(hi32), 64'h1234);
        chk("start_write_busy", 64'(busy32), 64'd1);
        wait_done(1'b0, 1, lat, bc, h, l);
        chk("start_write_result", {h, l}, {32'hFFFFFFFF, 32'hFFFFFFFA});

        // Reset in the middle of RUN.
        @(negedge clk);
        issue(1'b0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_state", {hi32, lo32}, 64'd0);
        chk("midreset_busy_done", 64'({busy32, done32}), 64'd0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        chk("midreset_no_done", 64'(ndone), 64'd0);
        issue(1'b0, 2'd0, 32'd6, 32'd7);
        wait_done(1'b0, 0, lat, bc, h, l);
        chk("after_reset_mul", {h, l}, {32'd0, 32'd42});

        // 8-bit instance: MULT 0x80*0x80 then back-to-back DIVU on the done cycle.
        issue(1'b1, 2'd1, 32'h80, 32'h80);
        wait_done(1'b1, 0, lat, bc, h, l);
        chk("w8_mult_result", {h, l}, {32'h40, 32'h00});
        chk("w8_mult_latency", 64'(lat), 64'd10);
        chk("w8_mult_busy_cycles", 64'(bc), 64'd9);
        issue(1'b1, 2'd2, 32'd200, 32'd9);
        wait_done(1'b1, 0, lat, bc, h, l);
        chk("w8_b2b_result", {h, l}, {32'd2, 32'd22});
        chk("w8_b2b_busy_cycles", 64'(bc), 64'd9);

        // Randomized ops on both widths against the reference model.
        for (int i = 0; i < 80; i++) begin
            bit w8;
            w8 = (i % 2) == 1;
            o = 2'($urandom_range(0, 3));
            x = pick(w8);
            y = pick(w8);
            issue(w8, o, x, y);
            wait_done(w8, 0, lat, bc, h, l);
            if (w8) begin
                e8 = ref8(o, x[7:0], y[7:0]);
                chk($sformatf("rand8 op=%0d a=%0h b=%0h", o, x, y), 64'({h[7:0], l[7:0]}), 64'(e8));
            end else begin
                e32 = ref32(o, x, y);
                chk($sformatf("rand32 op=%0d a=%0h b=%0h", o, x, y), {h, l}, e32);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
